// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, widths and the iterative-op classifier.
package alu_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CHUNK_BITS = 8;
    localparam int unsigned CNT_W      = $clog2(XLEN) + 1;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_SLT  = 4'b0101,
        ALU_CTZ  = 4'b0110,
        ALU_CLZ  = 4'b0111,
        ALU_CPOP = 4'b1000
    } alu_ctrl_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    function automatic logic is_iterative(input logic [3:0] code);
        return (code == ALU_CTZ) || (code == ALU_CLZ) || (code == ALU_CPOP);
    endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Issue/result bus between the pipeline and the execute-stage ALU.
interface alu_exec_unit_if;

    logic                     in_valid;
    logic                     in_ready;
    logic [3:0]               alu_ctrl;
    logic [alu_pkg::XLEN-1:0] src_a;
    logic [alu_pkg::XLEN-1:0] src_b;
    logic                     flush;
    logic                     out_valid;
    logic [alu_pkg::XLEN-1:0] result;
    logic                     zero;
    logic                     busy;

    modport master (
        output in_valid, alu_ctrl, src_a, src_b, flush,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  in_valid, alu_ctrl, src_a, src_b, flush,
        output in_ready, out_valid, result, zero, busy
    );

endinterface

// File: rtl/bit_chunk_count.sv
// Combinational zero/one counters over one operand chunk.
module bit_chunk_count #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]             chunk,
    output logic [$clog2(W):0]       lz,
    output logic [$clog2(W):0]       tz,
    output logic [$clog2(W):0]       pop,
    output logic                     any_one
);

    localparam int unsigned CW = $clog2(W) + 1;

    // Later iterations win: ascending finds the highest one, descending the lowest.
    always_comb begin
        lz  = CW'(W);
        tz  = CW'(W);
        pop = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (chunk[i]) lz = CW'(int'(W) - 1 - i);
            pop = pop + CW'(chunk[i]);
        end
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (chunk[i]) tz = CW'(i);
        end
    end

    assign any_one = |chunk;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic plus chunked CLZ/CTZ/CPOP scan.
module alu_exec_unit import alu_pkg::*; #(
    parameter int unsigned BITS_PER_CYCLE = CHUNK_BITS
) (
    input logic            clk,
    input logic            reset,
    alu_exec_unit_if.slave bus
);

    localparam int unsigned NCHUNK = XLEN / BITS_PER_CYCLE;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned CCW    = $clog2(BITS_PER_CYCLE) + 1;

    scan_state_e state, state_n;

    logic [3:0]          op_q;
    logic [XLEN-1:0]     opnd_q;
    logic [IDX_W-1:0]    idx_q, sel;
    logic [CNT_W-1:0]    acc_q, acc_n, add_c;
    logic                found_q, found_n, last;
    logic [XLEN-1:0]     alu_c;
    logic [XLEN-1:0]     result_q;
    logic                zero_q, out_valid_q;

    logic                ready, accept, start_scan, alu_done, scan_step, scan_done;

    logic [BITS_PER_CYCLE-1:0] chunk;
    logic [CCW-1:0]            lz, tz, pop;
    logic                      any_one;

    // CLZ walks from the MSB chunk down; CTZ/CPOP walk up from the LSB chunk.
    assign sel   = (op_q == ALU_CLZ) ? (IDX_W'(NCHUNK - 1) - idx_q) : idx_q;
    assign chunk = opnd_q[sel * BITS_PER_CYCLE +: BITS_PER_CYCLE];
    assign last  = (idx_q == IDX_W'(NCHUNK - 1));

    bit_chunk_count #(.W(BITS_PER_CYCLE)) u_count (
        .chunk   (chunk),
        .lz      (lz),
        .tz      (tz),
        .pop     (pop),
        .any_one (any_one)
    );

    // Sticky found flag freezes CLZ/CTZ once the first one is seen.
    always_comb begin
        add_c   = '0;
        found_n = found_q | any_one;
        case (op_q)
            ALU_CLZ: add_c = found_q ? '0 : CNT_W'(lz);
            ALU_CTZ: add_c = found_q ? '0 : CNT_W'(tz);
            default: add_c = CNT_W'(pop);
        endcase
        acc_n = acc_q + add_c;
    end

    always_comb begin
        alu_c = '0;
        case (bus.alu_ctrl)
            ALU_SUB: alu_c = bus.src_a - bus.src_b;
            ALU_AND: alu_c = bus.src_a & bus.src_b;
            ALU_OR:  alu_c = bus.src_a | bus.src_b;
            ALU_SLT: alu_c = XLEN'($signed(bus.src_a) < $signed(bus.src_b));
            default: alu_c = bus.src_a + bus.src_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (bus.flush) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept && is_iterative(bus.alu_ctrl)) state_n = ST_SCAN;
                ST_SCAN: if (last) state_n = ST_IDLE;
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ready      = (state == ST_IDLE);
        accept     = ready && bus.in_valid && !bus.flush;
        start_scan = accept && is_iterative(bus.alu_ctrl);
        alu_done   = accept && !is_iterative(bus.alu_ctrl);
        scan_step  = (state == ST_SCAN) && !bus.flush;
        scan_done  = scan_step && last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            op_q        <= '0;
            opnd_q      <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            found_q     <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (alu_done) begin
                out_valid_q <= 1'b1;
                result_q    <= alu_c;
                zero_q      <= (alu_c == '0);
            end
            if (start_scan) begin
                op_q    <= bus.alu_ctrl;
                opnd_q  <= bus.src_a;
                idx_q   <= '0;
                acc_q   <= '0;
                found_q <= 1'b0;
            end
            if (scan_step) begin
                idx_q   <= idx_q + IDX_W'(1);
                acc_q   <= acc_n;
                found_q <= found_n;
            end
            if (scan_done) begin
                out_valid_q <= 1'b1;
                result_q    <= XLEN'(acc_n);
                zero_q      <= (acc_n == '0);
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.busy      = !ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against a plain-arithmetic reference model.
module tb_alu_exec_unit;

    localparam int unsigned W      = 32;
    localparam int          SCAN_N = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [W-1:0] last_res;
    logic         last_zero;

    always #5 clk = ~clk;

    alu_exec_unit_if bus ();

    alu_exec_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_iter(input logic [3:0] c);
        return (c == 4'd6) || (c == 4'd7) || (c == 4'd8);
    endfunction

    function automatic logic [W-1:0] ref_alu(input logic [3:0] c, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int n;
        case (c)
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: begin
                n = 0;
                while (n < 32 && a[n] == 1'b0) n++;
                return 32'(n);
            end
            4'd7: begin
                n = 0;
                while (n < 32 && a[31-n] == 1'b0) n++;
                return 32'(n);
            end
            4'd8: return 32'($countones(a));
            default: return a + b;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge where out_valid is seen (or on timeout).
    task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold);
        logic [W-1:0] exp;
        int lat, busy_cnt, exp_lat;
        exp     = ref_alu(c, a, b);
        exp_lat = ref_iter(c) ? SCAN_N + 1 : 1;
        check("ready_at_issue", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.alu_ctrl = c;
        bus.src_a    = a;
        bus.src_b    = b;
        lat      = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!hold) bus.in_valid = 1'b0;
            if (!bus.out_valid && bus.busy && !bus.in_ready) busy_cnt++;
        end while (!bus.out_valid && lat < 20);
        bus.in_valid = 1'b0;
        check("latency", 32'(lat), 32'(exp_lat));
        check("busy_cycles", 32'(busy_cnt), 32'(exp_lat - 1));
        check($sformatf("result_c%0d", c), bus.result, exp);
        check("zero", 32'(bus.zero), 32'(exp == 0));
        last_res  = exp;
        last_zero = (exp == 0);
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        check(tag, 32'(pulses), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_ovalid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_result"}, bus.result, 32'd0);
        check({tag, "_zero"}, 32'(bus.zero), 32'd1);
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'd1 << $urandom_range(0, 31);
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.in_valid = 1'b0;
        bus.alu_ctrl = 4'd0;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.flush    = 1'b0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single-cycle ops
        run_op(4'd0, 32'd7, 32'd5, 1'b0);
        run_op(4'd1, 32'd5, 32'd5, 1'b0);
        run_op(4'd5, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op(4'd5, 32'd1, 32'hFFFF_FFFF, 1'b0);
        run_op(4'd15, 32'd3, 32'd4, 1'b0);

        // Iterative ops and boundaries
        run_op(4'd7, 32'h0001_0000, 32'd0, 1'b0);
        run_op(4'd6, 32'h0001_0000, 32'd0, 1'b0);
        run_op(4'd8, 32'hF0F0_0001, 32'd0, 1'b0);
        run_op(4'd7, 32'd0, 32'd9, 1'b0);
        run_op(4'd6, 32'd0, 32'd9, 1'b0);
        run_op(4'd8, 32'd0, 32'd9, 1'b0);
        run_op(4'd7, 32'h8000_0000, 32'd0, 1'b0);
        run_op(4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op(4'd6, 32'h8000_0000, 32'd0, 1'b0);

        // in_valid held through SCAN still yields one result
        run_op(4'd7, 32'h0000_0100, 32'd0, 1'b1);
        expect_quiet("held_single_result", 6);

        // Back-to-back ADD, CPOP, ADD
        run_op(4'd0, 32'd100, 32'd23, 1'b0);
        run_op(4'd8, 32'h0000_00FF, 32'd0, 1'b0);
        run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        @(negedge clk);

        // Flush in the second SCAN cycle
        run_op(4'd0, 32'd40, 32'd2, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.alu_ctrl = 4'd8; bus.src_a = 32'hFFFF_0000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_ready", 32'(bus.in_ready), 32'd1);
        check("flush_ovalid", 32'(bus.out_valid), 32'd0);
        check("flush_result", bus.result, last_res);
        check("flush_zero", 32'(bus.zero), 32'(last_zero));
        expect_quiet("flush_no_result", 6);

        // Flush together with in_valid in IDLE drops the op
        bus.in_valid = 1'b1; bus.alu_ctrl = 4'd0; bus.src_a = 32'd1; bus.src_b = 32'd1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        check("idle_flush_ovalid", 32'(bus.out_valid), 32'd0);
        check("idle_flush_result", bus.result, last_res);
        expect_quiet("idle_flush_quiet", 3);

        // Reset mid-SCAN
        run_op(4'd1, 32'd9, 32'd2, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.alu_ctrl = 4'd7; bus.src_a = 32'd1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_vals("midscan_reset");
        expect_quiet("midscan_reset_quiet", 6);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            logic [3:0] c;
            c = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) c = 4'($urandom_range(6, 8));
            run_op(c, rand_opnd(), rand_opnd(), ref_iter(c) && ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
